// File: rtl/store_buffer_if.sv
// Request/response and memory-port bundle for the store buffer.
// The slave modport is the buffer's view; the master modport is the view of
// whatever surrounds it (handler on the request side, memory on the mem side).
interface store_buffer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Handler request stream
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;

  // Load response
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;

  // Data memory port
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: stores are queued and drained to memory in the
// background, loads that hit a fully-written queued word are forwarded, and
// load misses go straight to memory while draining is paused.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus,
  output logic          empty
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WA_W   = ADDR_W - 2;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_REQ  = 2'd1,
    LD_WAIT = 2'd2,
    LD_RESP = 2'd3
  } state_t;

  // Control state
  state_t              state_q,     state_d;
  logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]    count_q,     count_d;
  logic [WA_W-1:0]     ld_addr_q,   ld_addr_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  // Entry storage
  logic [WA_W-1:0]     addr_q [DEPTH];
  logic [WA_W-1:0]     addr_d [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DATA_W-1:0]   data_d [DEPTH];
  logic [STRB_W-1:0]   strb_q [DEPTH];
  logic [STRB_W-1:0]   strb_d [DEPTH];

  // Request decode and match results
  logic [WA_W-1:0]     req_word;
  logic                hit;
  logic                hit_full;
  logic [DATA_W-1:0]   hit_data;
  logic                drain_active;
  logic                pop;
  logic                ready;
  logic                push;
  logic                ld_accept;
  logic [1:0]          unused_addr_lsb;

  assign req_word        = bus.req_addr[ADDR_W-1:2];
  assign unused_addr_lsb = bus.req_addr[1:0];

  // Youngest-match search over valid entries, walking oldest to youngest so
  // the last match seen wins.
  always_comb begin
    hit      = 1'b0;
    hit_full = 1'b0;
    hit_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) &&
          (addr_q[rd_ptr_q + PTR_W'(k)] == req_word)) begin
        hit      = 1'b1;
        hit_full = &strb_q[rd_ptr_q + PTR_W'(k)];
        hit_data = data_q[rd_ptr_q + PTR_W'(k)];
      end
    end
  end

  // Drain eligibility, request acceptance and handshake qualifiers.
  // A store may be accepted while full only when the head pops in the same
  // cycle, so ready depends combinationally on mem_req_ready in that case.
  always_comb begin
    drain_active = ((state_q == IDLE) || (state_q == LD_RESP)) &&
                   (count_q != '0);
    pop          = drain_active && bus.mem_req_ready;
    ready        = 1'b0;
    if (!reset && (state_q == IDLE)) begin
      if (bus.req_we) begin
        ready = (count_q < CNT_W'(DEPTH)) || pop;
      end else begin
        ready = !hit || hit_full;
      end
    end
    push      = bus.req_valid && ready && bus.req_we;
    ld_accept = bus.req_valid && ready && !bus.req_we;
  end

  // Next-state for pointers, count and entry storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strb_d   = strb_q;
    if (push) begin
      addr_d[wr_ptr_q] = req_word;
      data_d[wr_ptr_q] = bus.req_wdata;
      strb_d[wr_ptr_q] = bus.req_wstrb;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Load FSM next-state: hits go straight to the response, misses fetch.
  always_comb begin
    state_d     = state_q;
    ld_addr_d   = ld_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (ld_accept) begin
          if (hit) begin
            rsp_rdata_d = hit_data;
            state_d     = LD_RESP;
          end else begin
            ld_addr_d = req_word;
            state_d   = LD_REQ;
          end
        end
      end
      LD_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (bus.mem_rsp_valid) begin
          rsp_rdata_d = bus.mem_rdata;
          state_d     = LD_RESP;
        end
      end
      LD_RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ld_addr_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ld_addr_q   <= ld_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Entry storage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      strb_q <= strb_d;
    end
  end

  // Memory port mux: the pending read owns the port in LD_REQ, otherwise the
  // FIFO head is offered whenever draining is allowed.
  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.mem_wstrb     = '0;
    if (state_q == LD_REQ) begin
      bus.mem_req_valid = 1'b1;
      bus.mem_addr      = {ld_addr_q, 2'b00};
    end else if (drain_active) begin
      bus.mem_req_valid = 1'b1;
      bus.mem_we        = 1'b1;
      bus.mem_addr      = {addr_q[rd_ptr_q], 2'b00};
      bus.mem_wdata     = data_q[rd_ptr_q];
      bus.mem_wstrb     = strb_q[rd_ptr_q];
    end
  end

  // Handler-side outputs.
  always_comb begin
    bus.req_ready = ready;
    bus.rsp_valid = (state_q == LD_RESP);
    bus.rsp_rdata = rsp_rdata_q;
    empty         = (count_q == '0);
  end

endmodule
